temp_sample_ctrl: RTL and testbench



---
 rtl/temp_sample_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_temp_sample_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_ctrl.sv
// Temperature sample sequencer: paces sensor reads, hands each reading to the
// monitor with a one-cycle strobe, and latches an alarm on emergency state.
// Optional build macro TEMP_RANGE_CHECK_EN rejects the disconnected-sensor
// code (63 + 15/16) as a sensor fault instead of forwarding it.
module temp_sample_ctrl #(
  parameter int unsigned PERIOD  = 1000,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       sens_req,
  input  logic       sens_ack,
  input  logic [5:0] sens_temp,
  input  logic [3:0] sens_frac,
  output logic [5:0] mon_temp,
  output logic [3:0] mon_frac,
  output logic       mon_stb,
  output logic       mon_rst,
  input  logic [3:0] mon_state,
  output logic       alarm,
  input  logic       alarm_clr,
  output logic       fault,
  output logic [7:0] sample_cnt
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PERIOD_LD  = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_TICK = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] STROBE    = 3'd3;
  localparam logic [2:0] EVAL      = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;
  localparam logic [2:0] CLR       = 3'd6;

  localparam logic [3:0] MON_EMERGENCY = 4'd3;

  logic [2:0]    state, state_nxt;
  logic [PW-1:0] per_cnt, per_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          req_nxt, stb_nxt, mrst_nxt, alarm_nxt, fault_nxt;
  logic [5:0]    temp_nxt;
  logic [3:0]    frac_nxt;
  logic [7:0]    cnt_nxt;
  logic          reject;

  // Disconnected-sensor detection (all-ones reading)
`ifdef TEMP_RANGE_CHECK_EN
  assign reject = (sens_temp == 6'h3F) && (sens_frac == 4'hF);
`else
  assign reject = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    per_nxt   = per_cnt;
    to_nxt    = to_cnt;
    req_nxt   = sens_req;
    temp_nxt  = mon_temp;
    frac_nxt  = mon_frac;
    stb_nxt   = 1'b0;
    mrst_nxt  = 1'b0;
    alarm_nxt = alarm;
    fault_nxt = fault;
    cnt_nxt   = sample_cnt;

    // Operator clear outside HALT only drops the sensor fault; a new fault
    // raised in the same cycle below still takes precedence.
    if (alarm_clr && (state != HALT)) begin
      fault_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = WAIT_TICK;
          per_nxt   = PERIOD_LD;
        end
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (per_cnt == '0) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          to_nxt    = TIMEOUT_LD;
        end else begin
          per_nxt = per_cnt - PW'(1);
        end
      end
      REQ: begin
        if (!enable) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end else if (sens_ack) begin
          // Ack beats a simultaneous timeout expiry
          req_nxt = 1'b0;
          if (reject) begin
            fault_nxt = 1'b1;
            state_nxt = WAIT_TICK;
            per_nxt   = PERIOD_LD;
          end else begin
            temp_nxt  = sens_temp;
            frac_nxt  = sens_frac;
            stb_nxt   = 1'b1;
            state_nxt = STROBE;
          end
        end else if (to_cnt == '0) begin
          req_nxt   = 1'b0;
          fault_nxt = 1'b1;
          state_nxt = WAIT_TICK;
          per_nxt   = PERIOD_LD;
        end else begin
          to_nxt = to_cnt - TW'(1);
        end
      end
      STROBE: begin
        // The strobe already went out, so count it even on abort
        cnt_nxt   = sample_cnt + 8'd1;
        state_nxt = enable ? EVAL : IDLE;
      end
      EVAL: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (mon_state == MON_EMERGENCY) begin
          alarm_nxt = 1'b1;
          state_nxt = HALT;
        end else begin
          state_nxt = WAIT_TICK;
          per_nxt   = PERIOD_LD;
        end
      end
      HALT: begin
        if (alarm_clr) begin
          mrst_nxt  = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: begin
        alarm_nxt = 1'b0;
        fault_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      to_cnt     <= '0;
      sens_req   <= 1'b0;
      mon_temp   <= 6'd0;
      mon_frac   <= 4'd0;
      mon_stb    <= 1'b0;
      mon_rst    <= 1'b0;
      alarm      <= 1'b0;
      fault      <= 1'b0;
      sample_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      per_cnt    <= per_nxt;
      to_cnt     <= to_nxt;
      sens_req   <= req_nxt;
      mon_temp   <= temp_nxt;
      mon_frac   <= frac_nxt;
      mon_stb    <= stb_nxt;
      mon_rst    <= mrst_nxt;
      alarm      <= alarm_nxt;
      fault      <= fault_nxt;
      sample_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Bench for temp_sample_ctrl: directed scenarios with literal expectations,
// plus a sequential reference model compared against the DUT every cycle.
module tb_temp_sample_ctrl;

  localparam int unsigned P = 4;
  localparam int unsigned T = 8;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sens_req;
  logic       sens_ack;
  logic [5:0] sens_temp;
  logic [3:0] sens_frac;
  logic [5:0] mon_temp;
  logic [3:0] mon_frac;
  logic       mon_stb;
  logic       mon_rst;
  logic [3:0] mon_state;
  logic       alarm;
  logic       alarm_clr;
  logic       fault;
  logic [7:0] sample_cnt;

  temp_sample_ctrl #(.PERIOD(P), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sens_req(sens_req), .sens_ack(sens_ack),
    .sens_temp(sens_temp), .sens_frac(sens_frac),
    .mon_temp(mon_temp), .mon_frac(mon_frac),
    .mon_stb(mon_stb), .mon_rst(mon_rst), .mon_state(mon_state),
    .alarm(alarm), .alarm_clr(alarm_clr), .fault(fault),
    .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic expire(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " sens_req"}, int'(sens_req), 0);
    check({tag, " mon_temp"}, int'(mon_temp), 0);
    check({tag, " mon_frac"}, int'(mon_frac), 0);
    check({tag, " mon_stb"}, int'(mon_stb), 0);
    check({tag, " mon_rst"}, int'(mon_rst), 0);
    check({tag, " alarm"}, int'(alarm), 0);
    check({tag, " fault"}, int'(fault), 0);
    check({tag, " sample_cnt"}, int'(sample_cnt), 0);
  endtask

  // Count negedges until sens_req (sel 0) or mon_stb (sel 1) reaches lvl
  task automatic wait_sig(input string nm, input int sel, input logic lvl,
                          input int limit, output int n);
    logic v;
    bit   hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      v = (sel == 0) ? sens_req : mon_stb;
      if (v == lvl) hit = 1'b1;
    end
    if (!hit) begin
      expire(nm);
      n = -1;
    end
  endtask

  // ---------------- reference model ----------------
  logic       e_req, e_stb, e_rst, e_alarm, e_fault;
  logic [5:0] e_temp;
  logic [3:0] e_frac;
  logic [7:0] e_cnt;
  bit         restart;
  logic       s_en, s_ack, s_clr;
  logic [5:0] s_temp;
  logic [3:0] s_frac;
  logic [3:0] s_st;

  task automatic model_clear();
    e_req = 1'b0; e_stb = 1'b0; e_rst = 1'b0; e_alarm = 1'b0; e_fault = 1'b0;
    e_temp = 6'd0; e_frac = 4'd0; e_cnt = 8'd0;
  endtask

  // One clock edge: sample inputs, drop one-cycle pulses, apply reset/clear
  task automatic step(input bit halted);
    @(posedge clk);
    s_en = enable; s_ack = sens_ack; s_clr = alarm_clr;
    s_temp = sens_temp; s_frac = sens_frac; s_st = mon_state;
    e_stb = 1'b0;
    e_rst = 1'b0;
    if (rst) begin
      model_clear();
      restart = 1'b1;
    end else if (!halted && s_clr) begin
      e_fault = 1'b0;
    end
  endtask

  initial begin : model
    bit got;
    bit rej;
    model_clear();
    forever begin
      restart = 1'b0;
      step(1'b0);
      if (restart || !s_en) continue;
      forever begin
        got = 1'b0;
        for (int i = 0; i < P; i++) begin
          step(1'b0);
          if (restart || !s_en) break;
        end
        if (restart || !s_en) break;
        e_req = 1'b1;
        for (int i = 0; i < T; i++) begin
          step(1'b0);
          if (restart || !s_en) break;
          if (s_ack) begin got = 1'b1; break; end
        end
        e_req = 1'b0;
        if (restart || !s_en) break;
        if (!got) begin e_fault = 1'b1; continue; end
        rej = 1'b0;
`ifdef TEMP_RANGE_CHECK_EN
        rej = (s_temp == 6'h3F) && (s_frac == 4'hF);
`endif
        if (rej) begin e_fault = 1'b1; continue; end
        e_temp = s_temp; e_frac = s_frac; e_stb = 1'b1;
        step(1'b0);
        if (restart) break;
        e_cnt = e_cnt + 8'd1;
        if (!s_en) break;
        step(1'b0);
        if (restart || !s_en) break;
        if (s_st != 4'd3) continue;
        e_alarm = 1'b1;
        do step(1'b1); while (!restart && !s_clr);
        if (restart) break;
        e_rst = 1'b1;
        step(1'b0);
        if (restart) break;
        e_alarm = 1'b0;
        e_fault = 1'b0;
        break;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("sens_req", int'(sens_req), int'(e_req));
      check("mon_temp", int'(mon_temp), int'(e_temp));
      check("mon_frac", int'(mon_frac), int'(e_frac));
      check("mon_stb", int'(mon_stb), int'(e_stb));
      check("mon_rst", int'(mon_rst), int'(e_rst));
      check("alarm", int'(alarm), int'(e_alarm));
      check("fault", int'(fault), int'(e_fault));
      check("sample_cnt", int'(sample_cnt), int'(e_cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int n;
    int got;
    int guard;
    bit quiet;
    rst = 1'b1; enable = 1'b0; sens_ack = 1'b0; sens_temp = 6'd0;
    sens_frac = 4'd0; mon_state = 4'd0; alarm_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic sample: ack two clocks after request
    enable = 1'b1;
    wait_sig("s1 first req", 0, 1'b1, 20, n);
    check("s1 req latency", n, 5);
    @(negedge clk);
    sens_temp = 6'd25; sens_frac = 4'd3; sens_ack = 1'b1;
    @(negedge clk);
    sens_ack = 1'b0;
    check("s1 stb", int'(mon_stb), 1);
    check("s1 temp", int'(mon_temp), 25);
    check("s1 frac", int'(mon_frac), 3);
    wait_sig("s1 next req", 0, 1'b1, 20, n);
    check("s1 req spacing", n, 6);
    check("s1 cnt", int'(sample_cnt), 1);

    // Ack on the very cycle the timeout expires
    repeat (7) @(negedge clk);
    sens_temp = 6'd40; sens_frac = 4'd9; sens_ack = 1'b1;
    @(negedge clk);
    sens_ack = 1'b0;
    check("s4 stb", int'(mon_stb), 1);
    check("s4 fault", int'(fault), 0);
    check("s4 temp", int'(mon_temp), 40);

    // No ack: timeout, fault, retry, then clear fault outside HALT
    wait_sig("s2 req", 0, 1'b1, 20, n);
    check("s2 req gap", n, 6);
    wait_sig("s2 req drop", 0, 1'b0, 20, n);
    check("s2 req width", n, 8);
    check("s2 fault", int'(fault), 1);
    check("s2 temp kept", int'(mon_temp), 40);
    wait_sig("s2 retry", 0, 1'b1, 20, n);
    check("s2 retry gap", n, 4);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    check("s2 fault clr", int'(fault), 0);
    check("s2 alarm untouched", int'(alarm), 0);

    // Abort while requesting
    enable = 1'b0;
    @(negedge clk);
    check("abort req", int'(sens_req), 0);
    repeat (10) @(negedge clk);
    check("abort idle req", int'(sens_req), 0);
    check("abort cnt kept", int'(sample_cnt), 2);
    check("abort temp kept", int'(mon_temp), 40);

    // Emergency: halt, clear, monitor reset pulse, restart
    enable = 1'b1;
    wait_sig("s3 req", 0, 1'b1, 20, n);
    check("s3 req latency", n, 5);
    sens_temp = 6'd50; sens_frac = 4'd1; sens_ack = 1'b1; mon_state = 4'd3;
    @(negedge clk);
    sens_ack = 1'b0;
    check("s3 stb", int'(mon_stb), 1);
    @(negedge clk);
    @(negedge clk);
    check("s3 alarm", int'(alarm), 1);
    mon_state = 4'd0;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sens_req || mon_stb) quiet = 1'b0;
    end
    check("s3 halt quiet", int'(quiet), 1);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    check("s3 mon_rst", int'(mon_rst), 1);
    @(negedge clk);
    check("s3 mon_rst width", int'(mon_rst), 0);
    check("s3 alarm cleared", int'(alarm), 0);
    wait_sig("s3 restart", 0, 1'b1, 20, n);
    check("s3 restart latency", n, 5);

    // Asynchronous reset in the middle of a request
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset("s5 async");
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // 256 strobed samples wrap the counter
    enable = 1'b1;
    got = 0;
    guard = 0;
    while (got < 256 && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (mon_stb) got++;
      if (sens_req && !sens_ack) begin
        sens_temp = 6'(got % 63);
        sens_frac = 4'(got % 16);
        sens_ack = 1'b1;
      end else begin
        sens_ack = 1'b0;
      end
    end
    if (got < 256) expire("s6 strobes");
    sens_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("s6 wrap", int'(sample_cnt), 0);
    check("s6 last temp", int'(mon_temp), 3);

    // Disconnected-sensor code
    wait_sig("s7 req", 0, 1'b1, 20, n);
    sens_temp = 6'h3F; sens_frac = 4'hF; sens_ack = 1'b1;
    @(negedge clk);
    sens_ack = 1'b0;
`ifdef TEMP_RANGE_CHECK_EN
    check("s7 reject stb", int'(mon_stb), 0);
    check("s7 reject fault", int'(fault), 1);
    check("s7 temp kept", int'(mon_temp), 3);
`else
    check("s7 pass stb", int'(mon_stb), 1);
    check("s7 pass temp", int'(mon_temp), 63);
    check("s7 pass frac", int'(mon_frac), 15);
    check("s7 pass fault", int'(fault), 0);
`endif
    repeat (12) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
